// File: rtl/logic_accum_pkg.sv
// Shared types for the logic accumulate unit: op encoding, FSM states and
// the beat-counter sizing helper.
package logic_accum_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Counter must hold values 0..max_beats.
  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; head is registered so a push into an empty
// buffer is visible right after the pushing edge.
module sync_fifo2 #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [1:0]    count
);

  logic [1:0][DW-1:0] mem;
  logic               wp, rp;
  logic               do_push, do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop  && (count != 2'd0);
  assign rdata   = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/logic_accum_unit.sv
// Bitwise logic unit with optional multi-beat accumulate streams; results
// (with an overflow flag) are queued in a 2-entry output buffer.
module logic_accum_unit
  import logic_accum_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  localparam int CW = cnt_w(MAX_BEATS);

  function automatic logic [WIDTH-1:0] do_op(input op_e op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  state_e           state, state_n;
  op_e              op_q, op_n;
  logic [WIDTH-1:0] acc, acc_n, idle_res, acc_res;
  logic [CW-1:0]    cnt, cnt_n, cnt_inc;
  logic             accept, push, push_err, pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH:0]   head;
  logic [1:0]       fcnt;

  assign accept   = in_valid && in_ready;
  assign idle_res = do_op(op_e'(in_op), in_a, in_b);
  assign acc_res  = do_op(op_q, acc, in_a);
  assign cnt_inc  = cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= OP_AND;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    acc_n     = acc;
    cnt_n     = cnt;
    push      = 1'b0;
    push_data = '0;
    push_err  = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (!in_acc || in_last) begin
            push      = 1'b1;
            push_data = idle_res;
          end else begin
            acc_n   = idle_res;
            op_n    = op_e'(in_op);
            cnt_n   = CW'(1);
            state_n = ST_ACC;
          end
        end
        default: begin
          // Last beat closes normally; hitting MAX_BEATS forces the result out.
          if (in_last || cnt_inc == CW'(MAX_BEATS)) begin
            push      = 1'b1;
            push_data = acc_res;
            push_err  = !in_last;
            cnt_n     = '0;
            state_n   = ST_IDLE;
          end else begin
            acc_n = acc_res;
            cnt_n = cnt_inc;
          end
        end
      endcase
    end
  end

  sync_fifo2 #(.DW(WIDTH + 1)) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({push_err, push_data}),
    .pop   (pop),
    .rdata (head),
    .count (fcnt)
  );

  assign in_ready  = (fcnt != 2'd2);
  assign out_valid = (fcnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
  assign out_err   = out_valid && head[WIDTH];
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_logic_accum_unit.sv
// Directed bench for logic_accum_unit (WIDTH=4, MAX_BEATS=3 so overflow is reachable).
module tb_logic_accum_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0, in_b = '0;
  logic [1:0] in_op = '0;
  logic       in_acc = 1'b0, in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic       out_zero, out_err;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  logic_accum_unit #(.WIDTH(4), .MAX_BEATS(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_err(out_err)
  );

  // Present one beat, let one edge pass, then sample 1ns later.
  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic acc, input logic last);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else pass_cnt++;
    total++; if (out_data !== 4'b0000 || out_zero !== 1'b1 || out_err !== 1'b0)
      $display("FAIL reset_out got data=%b zero=%b err=%b want 0000/1/0", out_data, out_zero, out_err);
    else pass_cnt++;
    rst = 1'b0;
    idle_cycle();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    beat(4'b1101, 4'b1011, 2'b00, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 4'b1001)
      $display("FAIL single_data got v=%b d=%b want 1/1001", out_valid, out_data);
    else pass_cnt++;
    total++; if (out_zero !== 1'b0 || out_err !== 1'b0)
      $display("FAIL single_flags got zero=%b err=%b want 0/0", out_zero, out_err);
    else pass_cnt++;
    idle_cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_xor_stream();
    out_ready = 1'b1;
    beat(4'b0011, 4'b0101, 2'b10, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) $display("FAIL stream_beat1 got v=%b want 0", out_valid); else pass_cnt++;
    beat(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0) $display("FAIL stream_beat2 got v=%b want 0", out_valid); else pass_cnt++;
    beat(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 4'b1000 || out_err !== 1'b0)
      $display("FAIL stream_result got v=%b d=%b e=%b want 1/1000/0", out_valid, out_data, out_err);
    else pass_cnt++;
    idle_cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL stream_single got v=%b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(4'b0001, 4'b1111, 2'b00, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %b want 1", in_ready); else pass_cnt++;
    beat(4'b1100, 4'b0010, 2'b01, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0) $display("FAIL bp_ready2 got %b want 0", in_ready); else pass_cnt++;
    // Third beat offered while full: must be held, not consumed.
    in_valid = 1'b1; in_a = 4'b1010; in_b = 4'b1010; in_op = 2'b10; in_acc = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0 || out_data !== 4'b0001)
      $display("FAIL bp_hold got rdy=%b d=%b want 0/0001", in_ready, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_data !== 4'b1110 || in_ready !== 1'b1)
      $display("FAIL bp_second got d=%b rdy=%b want 1110/1", out_data, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 4'b0000 || out_zero !== 1'b1)
      $display("FAIL bp_third got v=%b d=%b z=%b want 1/0000/1", out_valid, out_data, out_zero);
    else pass_cnt++;
    idle_cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got v=%b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    beat(4'b0001, 4'b0000, 2'b01, 1'b1, 1'b0);
    beat(4'b0010, 4'b0000, 2'b00, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0) $display("FAIL ovf_early got v=%b want 0", out_valid); else pass_cnt++;
    beat(4'b0100, 4'b0000, 2'b00, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 4'b0111 || out_err !== 1'b1)
      $display("FAIL ovf_result got v=%b d=%b e=%b want 1/0111/1", out_valid, out_data, out_err);
    else pass_cnt++;
    beat(4'b0110, 4'b0011, 2'b00, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 4'b0010 || out_err !== 1'b0)
      $display("FAIL ovf_next got v=%b d=%b e=%b want 1/0010/0", out_valid, out_data, out_err);
    else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    beat(4'b0101, 4'b0101, 2'b00, 1'b0, 1'b0);
    beat(4'b1000, 4'b0000, 2'b01, 1'b1, 1'b0);
    beat(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 4'b0101)
      $display("FAIL rmid_pending got v=%b d=%b want 1/0101", out_valid, out_data);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'b0000)
      $display("FAIL rmid_async got v=%b rdy=%b d=%b want 0/1/0000", out_valid, in_ready, out_data);
    else pass_cnt++;
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    beat(4'b1111, 4'b1111, 2'b11, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 4'b0000 || out_zero !== 1'b1 || out_err !== 1'b0)
      $display("FAIL rmid_next got v=%b d=%b z=%b e=%b want 1/0000/1/0", out_valid, out_data, out_zero, out_err);
    else pass_cnt++;
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_xor_stream();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
